mpc_reg_arbiter: RTL and testbench
==================================

// Module: mpc_reg_arbiter
// PURPOSE
// - Sequences the AXI-lite register path from the PCI target onto PORT_NUM per-CAN-port register banks.
// - Arbitrates between the read and write channels and keeps one transaction in flight at a time.
// - Decodes the port index from the address and forwards each access as a strobe/ack register cycle.
// - Returns the response on B or R; unmapped ports get DECERR, unresponsive ports get SLVERR.
// PARAMETERS
// - PORT_NUM        4    number of CAN port register banks (1..16)
// - REG_AW          8    byte-address width inside one port bank
// - TIMEOUT_CYCLES  255  ack wait limit, timeout build only (1..65535)
// - IDX_W (localparam) = max(1, clog2(PORT_NUM)); port index = addr[REG_AW +: IDX_W]
// PORTS
// - aclk          in   1            register clock (CAN clock domain)
// - RST           in   1            reset, asynchronous, active-high
// - s_awvalid/s_awready  in/out 1/1  write address handshake
// - s_awaddr      in   32           write byte address
// - s_wvalid/s_wready    in/out 1/1  write data handshake
// - s_wdata       in   32           write data
// - s_wstrb       in   4            write byte strobes
// - s_bvalid/s_bready    out/in 1/1  write response handshake
// - s_bresp       out  2            00 OKAY, 10 SLVERR, 11 DECERR
// - s_arvalid/s_arready  in/out 1/1  read address handshake
// - s_araddr      in   32           read byte address
// - s_aruser      in   4            read byte enables
// - s_rvalid/s_rready    out/in 1/1  read data handshake
// - s_rdata       out  32           read data
// - s_rresp       out  2            same encoding as s_bresp
// - reg_sel       out  PORT_NUM     one-hot bank select, held until ack
// - reg_wr        out  1            1 = write, 0 = read
// - reg_addr      out  REG_AW       byte offset inside the bank
// - reg_wdata     out  32           write data
// - reg_be        out  4            s_wstrb on writes, s_aruser on reads
// - reg_rdata     in   32*PORT_NUM  read data; bank i in bits [32i+31:32i]
// - reg_ack       in   PORT_NUM     one-cycle completion pulse per bank
// BEHAVIOUR
// - Reset: every output is 0 (including ready/valid, resp, rdata, reg_*), FSM goes to IDLE, rr_last = READ.
// - RST during any state aborts the access; the bank sees reg_sel drop asynchronously.
// - FSM states: IDLE -> ISSUE -> RESP -> IDLE.
// - IDLE, write candidate: s_awvalid && s_wvalid are both high (AW alone is never accepted).
// - IDLE, read candidate: s_arvalid.
// - IDLE, both candidates: the grant goes opposite to rr_last; otherwise the lone candidate wins.
// - Grant: the matching ready(s) pulse for exactly 1 cycle; address, data, strobes and byte enables are latched; rr_last is updated.
// - Index decode, idx >= PORT_NUM: skip ISSUE, go straight to RESP with resp = 11 and rdata = 0.
// - Index decode, idx < PORT_NUM: in ISSUE, reg_sel[idx] and reg_wr/addr/wdata/be are registered on the cycle after the grant and held stable.
// - ISSUE ends on reg_ack[idx]: reg_sel clears, rdata latches reg_rdata[idx] on reads, resp = 00, next state RESP.
// - ISSUE ignores reg_ack bits for unselected banks.
// - RESP: s_bvalid or s_rvalid is held with stable data until the matching ready.
// - RESP exit: at the handshake cycle go to IDLE; valid drops the next cycle; the next grant comes no earlier than 1 cycle after that.
// - Minimum latency: grant at T0, reg_sel at T1; ack at T1 gives valid at T2.
// - No AXI ready is asserted outside IDLE, so the block never holds two transactions.
// CONFIGURATION
// - Macro MPC_REG_ARB_TIMEOUT_EN, defined:
//   - a 16-bit counter clears on entering ISSUE and counts each ISSUE cycle.
//   - After TIMEOUT_CYCLES cycles without ack: reg_sel drops, go to RESP with resp = 10 and rdata = 32'h0.
//   - An ack arriving in the same cycle as expiry wins and gives OKAY.
// - Macro undefined: no counter; ISSUE waits for ack indefinitely.
// TESTING
// - Write 0x0000_0104 with data 0xA5A5_0001 and wstrb 0xF; bank 1 acks 3 cycles later
//   -> reg_sel = 0010, reg_addr = 0x04, reg_be = F; then bvalid with bresp = 00.
// - Read 0x0000_0308 with aruser 0x3; bank 3 returns 0x1234_5678
//   -> rdata = 0x1234_5678, rresp = 00, reg_be = 3, reg_wr = 0.
// - AW+W and AR asserted in the same cycle right after reset (rr_last = READ)
//   -> write granted first, read granted after B handshake; repeat -> read now granted first.
// - Read 0x0000_0400 with PORT_NUM = 4
//   -> no reg_sel activity; rvalid 1 cycle after grant, rresp = 11, rdata = 0.
// - Timeout build, TIMEOUT_CYCLES = 8, bank 2 never acks
//   -> reg_sel[2] high 8 cycles, then bresp = 10; the next access proceeds normally.
// - RST pulse while reg_sel[0] is high, and s_rready held low during RESP
//   -> all outputs 0 immediately on reset; rvalid/rdata stay stable until s_rready.

Source files
------------

// File: rtl/mpc_reg_arbiter.sv
// AXI-lite to per-CAN-port register bank sequencer: one transaction in flight,
// read/write round-robin. Optional ack timeout under `MPC_REG_ARB_TIMEOUT_EN`.
module mpc_reg_arbiter #(
  parameter int unsigned PORT_NUM       = 4,
  parameter int unsigned REG_AW         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    aclk,
  input  logic                    RST,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [31:0]             s_awaddr,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [31:0]             s_araddr,
  input  logic [3:0]              s_aruser,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic [PORT_NUM-1:0]     reg_sel,
  output logic                    reg_wr,
  output logic [REG_AW-1:0]       reg_addr,
  output logic [31:0]             reg_wdata,
  output logic [3:0]              reg_be,
  input  logic [32*PORT_NUM-1:0]  reg_rdata,
  input  logic [PORT_NUM-1:0]     reg_ack
);

  localparam int unsigned IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  if (PORT_NUM == 0 || PORT_NUM > 16 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mpc_reg_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  rr_last_q, rr_last_d;   // 1 = last grant was a write
  logic                  s_awready_q, s_awready_d;
  logic                  s_wready_q, s_wready_d;
  logic                  s_arready_q, s_arready_d;
  logic                  s_bvalid_q, s_bvalid_d;
  logic [1:0]            s_bresp_q, s_bresp_d;
  logic                  s_rvalid_q, s_rvalid_d;
  logic [31:0]           s_rdata_q, s_rdata_d;
  logic [1:0]            s_rresp_q, s_rresp_d;
  logic [PORT_NUM-1:0]   reg_sel_q, reg_sel_d;
  logic                  reg_wr_q, reg_wr_d;
  logic [REG_AW-1:0]     reg_addr_q, reg_addr_d;
  logic [31:0]           reg_wdata_q, reg_wdata_d;
  logic [3:0]            reg_be_q, reg_be_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
`ifdef MPC_REG_ARB_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  logic [31:0]           gnt_addr;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_unmapped;
  logic                  ack_hit;
  logic [31:0]           sel_rdata;

  // Read data mux for the bank currently being accessed
  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (idx_q == IDX_W'(i)) sel_rdata = reg_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    s_awready_d = 1'b0;
    s_wready_d  = 1'b0;
    s_arready_d = 1'b0;
    s_bvalid_d  = s_bvalid_q;
    s_bresp_d   = s_bresp_q;
    s_rvalid_d  = s_rvalid_q;
    s_rdata_d   = s_rdata_q;
    s_rresp_d   = s_rresp_q;
    reg_sel_d   = reg_sel_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    idx_d       = idx_q;
`ifdef MPC_REG_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    // rr_last_q already reflects the direction of the transaction being granted
    gnt_addr     = rr_last_q ? s_awaddr : s_araddr;
    gnt_idx      = gnt_addr[REG_AW +: IDX_W];
    // Any address bit above the bank offset counts toward the port number
    gnt_unmapped = 32'(gnt_addr[31:REG_AW]) >= PORT_NUM;
    ack_hit      = |(reg_ack & reg_sel_q);

    unique case (state_q)
      S_IDLE: begin
        if (s_awready_q || s_arready_q) begin
          if (gnt_unmapped) begin
            state_d = S_RESP;
            if (rr_last_q) begin
              s_bvalid_d = 1'b1;
              s_bresp_d  = RESP_DECERR;
            end else begin
              s_rvalid_d = 1'b1;
              s_rresp_d  = RESP_DECERR;
              s_rdata_d  = '0;
            end
          end else begin
            state_d    = S_ISSUE;
            idx_d      = gnt_idx;
            reg_sel_d  = PORT_NUM'(1) << gnt_idx;
            reg_wr_d   = rr_last_q;
            reg_addr_d = gnt_addr[REG_AW-1:0];
            reg_be_d   = rr_last_q ? s_wstrb : s_aruser;
            if (rr_last_q) reg_wdata_d = s_wdata;
`ifdef MPC_REG_ARB_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end
        end else if (s_awvalid && s_wvalid && (!s_arvalid || !rr_last_q)) begin
          s_awready_d = 1'b1;
          s_wready_d  = 1'b1;
          rr_last_d   = 1'b1;
        end else if (s_arvalid) begin
          s_arready_d = 1'b1;
          rr_last_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        if (ack_hit) begin
          state_d   = S_RESP;
          reg_sel_d = '0;
          if (rr_last_q) begin
            s_bvalid_d = 1'b1;
            s_bresp_d  = RESP_OKAY;
          end else begin
            s_rvalid_d = 1'b1;
            s_rresp_d  = RESP_OKAY;
            s_rdata_d  = sel_rdata;
          end
        end
`ifdef MPC_REG_ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_RESP;
          reg_sel_d = '0;
          if (rr_last_q) begin
            s_bvalid_d = 1'b1;
            s_bresp_d  = RESP_SLVERR;
          end else begin
            s_rvalid_d = 1'b1;
            s_rresp_d  = RESP_SLVERR;
            s_rdata_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      S_RESP: begin
        if (s_bvalid_q && s_bready) begin
          s_bvalid_d = 1'b0;
          state_d    = S_IDLE;
        end
        if (s_rvalid_q && s_rready) begin
          s_rvalid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rr_last_q   <= 1'b0;
      s_awready_q <= 1'b0;
      s_wready_q  <= 1'b0;
      s_arready_q <= 1'b0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= '0;
      s_rvalid_q  <= 1'b0;
      s_rdata_q   <= '0;
      s_rresp_q   <= '0;
      reg_sel_q   <= '0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= '0;
      idx_q       <= '0;
`ifdef MPC_REG_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      s_awready_q <= s_awready_d;
      s_wready_q  <= s_wready_d;
      s_arready_q <= s_arready_d;
      s_bvalid_q  <= s_bvalid_d;
      s_bresp_q   <= s_bresp_d;
      s_rvalid_q  <= s_rvalid_d;
      s_rdata_q   <= s_rdata_d;
      s_rresp_q   <= s_rresp_d;
      reg_sel_q   <= reg_sel_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      idx_q       <= idx_d;
`ifdef MPC_REG_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign s_awready = s_awready_q;
  assign s_wready  = s_wready_q;
  assign s_arready = s_arready_q;
  assign s_bvalid  = s_bvalid_q;
  assign s_bresp   = s_bresp_q;
  assign s_rvalid  = s_rvalid_q;
  assign s_rdata   = s_rdata_q;
  assign s_rresp   = s_rresp_q;
  assign reg_sel   = reg_sel_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;

endmodule

// File: tb/tb_mpc_reg_arbiter.sv
// Directed bench for mpc_reg_arbiter: vector table plus arbitration, reset and
// (with MPC_REG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8) timeout sequences.
module tb_mpc_reg_arbiter;

  localparam int unsigned PN = 4;

  logic          aclk, RST;
  logic          s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0]   s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]    s_wstrb, s_aruser, reg_be;
  logic [1:0]    s_bresp, s_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready;
  logic [PN-1:0] reg_sel, reg_ack;
  logic          reg_wr;
  logic [7:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [32*PN-1:0] reg_rdata;

  int checks = 0;
  int failures = 0;

  mpc_reg_arbiter #(.PORT_NUM(PN), .REG_AW(8), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .RST(RST),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_aruser(s_aruser),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] bank_rd;
    int          delay;
    int          hold;
    bit          decerr;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_addr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input bit wr, input string name);
    int n = 0;
    while (((wr ? s_awready : s_arready) !== 1'b1) && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_ready"}, wr ? s_awready : s_arready, 1'b1);
    if (wr) chk({name, "_wready"}, s_wready, 1'b1);
  endtask

  task automatic ack_bank(input int bank, input logic [31:0] rd);
    reg_rdata[32*bank +: 32] = rd;
    reg_ack[bank] = 1'b1;
    tick();
    reg_ack = '0;
  endtask

  task automatic finish_resp(input bit wr, input int hold, input logic [31:0] exp_rd, input string name);
    bit stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if ((wr ? s_bvalid : s_rvalid) !== 1'b1) stable = 1'b0;
      if (!wr && s_rdata !== exp_rd) stable = 1'b0;
    end
    if (hold > 0) chk({name, "_hold"}, stable, 1'b1);
    if (wr) s_bready = 1'b1; else s_rready = 1'b1;
    tick();
    s_bready = 1'b0;
    s_rready = 1'b0;
    chk({name, "_vdrop"}, wr ? s_bvalid : s_rvalid, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit stable = 1'b1;
    if (v.wr) begin
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = v.addr; s_wdata = v.wdata; s_wstrb = v.be;
    end else begin
      s_arvalid = 1'b1; s_araddr = v.addr; s_aruser = v.be;
    end
    wait_ready(v.wr, name);
    tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    if (v.decerr) begin
      chk({name, "_nosel"}, reg_sel, 4'b0000);
      chk({name, "_valid"}, v.wr ? s_bvalid : s_rvalid, 1'b1);
      chk({name, "_resp"}, v.wr ? s_bresp : s_rresp, 2'b11);
      if (!v.wr) chk({name, "_rdata"}, s_rdata, 32'h0);
    end else begin
      chk({name, "_sel"}, reg_sel, v.exp_sel);
      chk({name, "_wr"}, reg_wr, v.wr);
      chk({name, "_addr"}, reg_addr, v.exp_addr);
      chk({name, "_be"}, reg_be, v.be);
      if (v.wr) chk({name, "_wdata"}, reg_wdata, v.wdata);
      for (int d = 0; d < v.delay; d++) begin
        tick();
        if (reg_sel !== v.exp_sel || s_bvalid !== 1'b0 || s_rvalid !== 1'b0) stable = 1'b0;
      end
      if (v.delay > 0) chk({name, "_selhold"}, stable, 1'b1);
      ack_bank($clog2(int'(v.exp_sel)), v.bank_rd);
      chk({name, "_selclr"}, reg_sel, 4'b0000);
      chk({name, "_valid"}, v.wr ? s_bvalid : s_rvalid, 1'b1);
      chk({name, "_resp"}, v.wr ? s_bresp : s_rresp, v.exp_resp);
      if (!v.wr) chk({name, "_rdata"}, s_rdata, v.exp_rdata);
    end
    finish_resp(v.wr, v.hold, v.exp_rdata, name);
  endtask

  initial begin
    // wr, addr, wdata, be, bank_rd, delay, hold, decerr, exp_sel, exp_addr, exp_rdata, exp_resp
    vecs[0] = '{1'b1, 32'h0000_0104, 32'hA5A5_0001, 4'hF, 32'h0, 3, 0, 1'b0, 4'b0010, 8'h04, 32'h0, 2'b00};
    vecs[1] = '{1'b0, 32'h0000_0308, 32'h0, 4'h3, 32'h1234_5678, 1, 3, 1'b0, 4'b1000, 8'h08, 32'h1234_5678, 2'b00};
    vecs[2] = '{1'b0, 32'h0000_0400, 32'h0, 4'hF, 32'h0, 0, 2, 1'b1, 4'b0000, 8'h00, 32'h0, 2'b11};
    vecs[3] = '{1'b1, 32'h0000_00FC, 32'hDEAD_BEEF, 4'h5, 32'h0, 0, 1, 1'b0, 4'b0001, 8'hFC, 32'h0, 2'b00};
    vecs[4] = '{1'b1, 32'h0000_2010, 32'h1111_2222, 4'hF, 32'h0, 0, 0, 1'b1, 4'b0000, 8'h00, 32'h0, 2'b11};
    vecs[5] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'hCAFE_F00D, 2, 0, 1'b0, 4'b0001, 8'h10, 32'hCAFE_F00D, 2'b00};

    RST = 1'b1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0; s_aruser = '0;
    reg_rdata = '0; reg_ack = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("reset_outs", {s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rdata,
                       s_rresp, reg_sel, reg_wr, reg_addr, reg_wdata, reg_be}, '0);

    // Arbitration: simultaneous requests after reset go to the write first
    s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h100; s_wdata = 32'h0000_00AA; s_wstrb = 4'hF;
    s_arvalid = 1; s_araddr = 32'h204; s_aruser = 4'hF;
    wait_ready(1'b1, "arb1_wr");
    chk("arb1_noar", s_arready, 1'b0);
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("arb1_sel", reg_sel, 4'b0010);
    ack_bank(1, 32'h0);
    chk("arb1_bvalid", s_bvalid, 1'b1);
    chk("arb1_noar_resp", s_arready, 1'b0);
    s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h300; s_wdata = 32'h0000_00BB;
    s_bready = 1;
    tick();
    s_bready = 0;
    chk("arb_gap", {s_arready, s_awready, s_bvalid}, 3'b000);
    tick();
    chk("arb2_rd_ready", s_arready, 1'b1);
    chk("arb2_noaw", s_awready, 1'b0);
    tick();
    s_arvalid = 0;
    chk("arb2_sel", reg_sel, 4'b0100);
    ack_bank(2, 32'hBEEF_0002);
    chk("arb2_rdata", s_rdata, 32'hBEEF_0002);
    finish_resp(1'b0, 0, 32'hBEEF_0002, "arb2");
    wait_ready(1'b1, "arb3_wr");
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("arb3_sel", reg_sel, 4'b1000);
    chk("arb3_wdata", reg_wdata, 32'h0000_00BB);
    ack_bank(3, 32'h0);
    finish_resp(1'b1, 0, 32'h0, "arb3");

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Wrong-bank ack is ignored; RST aborts the access asynchronously
    s_arvalid = 1; s_araddr = 32'h0000_0020; s_aruser = 4'h1;
    wait_ready(1'b0, "rst_rd");
    tick();
    s_arvalid = 0;
    chk("rst_sel", reg_sel, 4'b0001);
    ack_bank(1, 32'h5555_5555);
    chk("wrongack_norvalid", s_rvalid, 1'b0);
    chk("wrongack_selheld", reg_sel, 4'b0001);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async_outs", {s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rdata,
                           s_rresp, reg_sel, reg_wr, reg_addr, reg_wdata, reg_be}, '0);
    tick();
    RST = 1'b0;
    tick();
    run_vec(vecs[1], "post_rst");

`ifdef MPC_REG_ARB_TIMEOUT_EN
    begin
      int n = 0;
      s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h208; s_wdata = 32'h7777_0000; s_wstrb = 4'hF;
      wait_ready(1'b1, "to_wr");
      tick();
      s_awvalid = 0; s_wvalid = 0;
      while (reg_sel == 4'b0100 && n < 40) begin
        n++;
        tick();
      end
      chk("to_sel_cycles", n, 8);
      chk("to_bvalid", s_bvalid, 1'b1);
      chk("to_bresp", s_bresp, 2'b10);
      finish_resp(1'b1, 0, 32'h0, "to");
      run_vec(vecs[5], "post_to");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
